key_filter: RTL and testbench

// Input-side companion of the flip_flop LED path: conditions a raw mechanical key into clean

---
 rtl/key_filter.sv | 120 ++++++++++++
 tb/tb_key_filter.sv | 85 ++++++++
 2 files changed

// File: rtl/key_filter.sv
// Key conditioner: synchronises a raw mechanical key, rejects bounce with a
// hold-time counter, and produces a debounced level plus press/release pulses.
module key_filter #(
  parameter int CNT_MAX        = 999_999,
  parameter int SYNC_STAGES    = 2,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_state,
  output logic key_flag,
  output logic key_release_flag
);

  localparam int            CW       = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);
  localparam logic          RELEASED = KEY_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FLT,
    PRESSED,
    REL_FLT
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_state_q, key_state_d;
  logic          key_flag_q, key_flag_d;
  logic          key_rel_q, key_rel_d;

  // Reset preloads the released level so no phantom press is seen afterwards.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= {SYNC_STAGES{RELEASED}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
    end
  end

  assign pressed = sync_q[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_state_q <= 1'b0;
      key_flag_q  <= 1'b0;
      key_rel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      key_flag_q  <= key_flag_d;
      key_rel_q   <= key_rel_d;
    end
  end

  // Any reversion while filtering drops back to the previous stable state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_state_d = key_state_q;
    key_flag_d  = 1'b0;
    key_rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pressed) begin
          state_d = PRESS_FLT;
        end
      end
      PRESS_FLT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = PRESSED;
          key_state_d = 1'b1;
          key_flag_d  = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (!pressed) begin
          state_d = REL_FLT;
        end
      end
      REL_FLT: begin
        if (pressed) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          key_state_d = 1'b0;
          key_rel_d   = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_state        = key_state_q;
  assign key_flag         = key_flag_q;
  assign key_release_flag = key_rel_q;

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with a short filter (CNT_MAX=9), checking
// {key_state, key_flag, key_release_flag} after every clock edge.
module tb_key_filter;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic key_state, key_flag, key_release_flag;

  int vectors    = 0;
  int miscompares = 0;

  key_filter #(
    .CNT_MAX(9),
    .SYNC_STAGES(2),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .key_in(key_in),
    .key_state(key_state),
    .key_flag(key_flag),
    .key_release_flag(key_release_flag)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed state/flag/rel=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drives the pin, then checks the outputs 1 time unit after each of the next edges.
  task automatic applyStimulus(input logic pin, input int cycles, input logic [2:0] exp,
                               input string tag);
    key_in = pin;
    for (int i = 0; i < cycles; i++) begin
      @(posedge sys_clk);
      #1;
      checkOutput($sformatf("%s[%0d]", tag, i), {key_state, key_flag, key_release_flag}, exp);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 3, 3'b000, "reset");
    sys_rst = 1'b0;
    applyStimulus(1'b1, 2, 3'b000, "idle");

    applyStimulus(1'b0, 12, 3'b000, "press_wait");
    applyStimulus(1'b0, 1, 3'b110, "press_flag");
    applyStimulus(1'b0, 3, 3'b100, "press_hold");

    applyStimulus(1'b1, 12, 3'b100, "rel_wait");
    applyStimulus(1'b1, 1, 3'b001, "rel_flag");
    applyStimulus(1'b1, 3, 3'b000, "rel_idle");

    applyStimulus(1'b0, 5, 3'b000, "bounce_low");
    applyStimulus(1'b1, 1, 3'b000, "bounce_high");
    applyStimulus(1'b0, 12, 3'b000, "bounce_wait");
    applyStimulus(1'b0, 1, 3'b110, "bounce_flag");
    applyStimulus(1'b0, 4, 3'b100, "bounce_hold");

    applyStimulus(1'b1, 12, 3'b100, "rel2_wait");
    applyStimulus(1'b1, 1, 3'b001, "rel2_flag");
    applyStimulus(1'b1, 2, 3'b000, "rel2_idle");

    applyStimulus(1'b0, 8, 3'b000, "glitch_low");
    applyStimulus(1'b1, 12, 3'b000, "glitch_after");

    applyStimulus(1'b0, 8, 3'b000, "rstmid_filter");
    sys_rst = 1'b1;
    applyStimulus(1'b0, 2, 3'b000, "rstmid_reset");
    sys_rst = 1'b0;
    applyStimulus(1'b0, 12, 3'b000, "rstmid_wait");
    applyStimulus(1'b0, 1, 3'b110, "rstmid_flag");
    applyStimulus(1'b0, 2, 3'b100, "rstmid_hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
